// File: rtl/uart_rx_ctrl.sv
// RX-path controller: sequences receiver bytes into the RX FIFO, turns APB RXDATA
// reads into timed FIFO pops, tracks occupancy and raises status/interrupt flags.
module uart_rx_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       fifo_push,
    output logic [7:0]                 fifo_wdata,
    output logic                       fifo_pop,
    input  logic [7:0]                 fifo_rdata,
    input  logic                       rd_req,
    output logic                       rd_done,
    output logic [7:0]                 rd_data,
    input  logic [3:0]                 thr,
    input  logic                       clr_status,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovr,
    output logic                       udf,
    output logic                       irq_thr,
    output logic                       irq_tmo,
    output logic                       irq
);

    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam int CMPW = (LW > 4) ? LW : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_DONE,
        S_EMPTY
    } state_t;

    state_t          state_reg;
    logic [LW-1:0]   level_reg, level_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            fifo_push_reg;
    logic [7:0]      fifo_wdata_reg;
    logic            fifo_pop_reg;
    logic            rd_done_reg;
    logic [7:0]      rd_data_reg;
    logic            ovr_reg, ovr_next;
    logic            udf_reg, udf_next;
    logic            irq_thr_reg, irq_thr_next;
    logic            irq_tmo_reg, irq_tmo_next;
    logic            irq_reg;

    logic level_full, level_empty;
    logic accept, drop;
    logic rd_start, pop_start, empty_rd;

    always_comb begin
        level_full  = (level_reg == LW'(DEPTH));
        level_empty = (level_reg == '0);
        // Fullness is judged on the registered level, so a pop decided on the
        // same edge never makes room for the byte arriving with it.
        accept      = rx_valid && !level_full;
        drop        = rx_valid && level_full;
        rd_start    = (state_reg == S_IDLE) && rd_req;
        pop_start   = rd_start && !level_empty;
        empty_rd    = rd_start && level_empty;

        level_next = level_reg;
        if (accept && !pop_start) begin
            level_next = level_reg + LW'(1);
        end else if (!accept && pop_start) begin
            level_next = level_reg - LW'(1);
        end

        count_next = count_reg;
        if (accept || rd_done_reg || level_empty) begin
            count_next = '0;
        end else if (count_reg != CW'(TIMEOUT)) begin
            count_next = count_reg + CW'(1);
        end

        ovr_next     = drop || (ovr_reg && !clr_status);
        udf_next     = empty_rd || (udf_reg && !clr_status);
        irq_thr_next = (thr != 4'd0) && (CMPW'(level_next) >= CMPW'(thr));
        irq_tmo_next = (count_next == CW'(TIMEOUT)) && (level_next != '0);
    end

    // Occupancy, push strobe, flags and interrupts.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg      <= '0;
            count_reg      <= '0;
            fifo_push_reg  <= 1'b0;
            fifo_wdata_reg <= 8'h00;
            ovr_reg        <= 1'b0;
            udf_reg        <= 1'b0;
            irq_thr_reg    <= 1'b0;
            irq_tmo_reg    <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            level_reg     <= level_next;
            count_reg     <= count_next;
            fifo_push_reg <= accept;
            if (accept) begin
                fifo_wdata_reg <= rx_data;
            end
            ovr_reg     <= ovr_next;
            udf_reg     <= udf_next;
            irq_thr_reg <= irq_thr_next;
            irq_tmo_reg <= irq_tmo_next;
            irq_reg     <= irq_thr_next | irq_tmo_next | ovr_next | udf_next;
        end
    end

    // Read sequencer; strobes are raised on the edge entering their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            fifo_pop_reg <= 1'b0;
            rd_done_reg  <= 1'b0;
            rd_data_reg  <= 8'h00;
        end else begin
            fifo_pop_reg <= 1'b0;
            rd_done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pop_start) begin
                        state_reg    <= S_POP;
                        fifo_pop_reg <= 1'b1;
                    end else if (empty_rd) begin
                        state_reg   <= S_EMPTY;
                        rd_done_reg <= 1'b1;
                        rd_data_reg <= 8'h00;
                    end
                end
                S_POP: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // FIFO read data is registered, so it is valid only now.
                    rd_data_reg <= fifo_rdata;
                    rd_done_reg <= 1'b1;
                    state_reg   <= S_DONE;
                end
                S_DONE:  state_reg <= S_IDLE;
                S_EMPTY: state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign fifo_push  = fifo_push_reg;
    assign fifo_wdata = fifo_wdata_reg;
    assign fifo_pop   = fifo_pop_reg;
    assign rd_done    = rd_done_reg;
    assign rd_data    = rd_data_reg;
    assign level      = level_reg;
    assign ovr        = ovr_reg;
    assign udf        = udf_reg;
    assign irq_thr    = irq_thr_reg;
    assign irq_tmo    = irq_tmo_reg;
    assign irq        = irq_reg;

endmodule
